post_code_buffer: RTL and testbench



---
 rtl/post_code_buffer_pkg.sv | 10 +
 rtl/post_code_buffer_if.sv | 8 +
 rtl/post_code_fifo.sv | 43 ++++
 rtl/post_code_buffer.sv | 82 ++++++++
 tb/tb_post_code_buffer.sv | 173 +++++++++++++++++
 5 files changed

// File: rtl/post_code_buffer_pkg.sv
// post_pkg: shared constants, FSM encoding and hold-time default for the POST code path
package post_pkg;
  localparam logic [15:0] POST_IO_ADDR = 16'h0080;
  typedef enum logic {ST_IDLE = 1'b0, ST_HOLD = 1'b1} post_state_t;
`ifdef SIMULATE_DESIGN
  localparam int HOLD_MS_DEFAULT = 4;
`else
  localparam int HOLD_MS_DEFAULT = 250;
`endif
endpackage

// File: rtl/post_code_buffer_if.sv
// post_code_buffer_if: host I/O write bus snooped for POST codes
interface post_code_buffer_if;
  logic        IoWrStb;
  logic [15:0] IoAddr;
  logic [7:0]  IoData;
  modport master (output IoWrStb, IoAddr, IoData);
  modport slave  (input  IoWrStb, IoAddr, IoData);
endinterface

// File: rtl/post_code_fifo.sv
// post_code_fifo: sync FIFO with flush; a push while full drops the oldest entry
module post_code_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic                     Mclk,
  input  logic                     ResetN,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         wr_data,
  output logic [WIDTH-1:0]         rd_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             adv_rd;
  assign empty   = count == '0;
  assign full    = count == (AW+1)'(DEPTH);
  assign rd_data = mem[rd_ptr];
  // a pop and an overwrite on the same edge both retire just the head entry
  assign adv_rd  = (pop && !empty) || (push && full);
  always_ff @(posedge Mclk or negedge ResetN) begin
    if (!ResetN) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (adv_rd) rd_ptr <= rd_ptr + 1'b1;
      if (push && !adv_rd) count <= count + 1'b1;
      else if (!push && adv_rd) count <= count - 1'b1;
    end
  end
  always_ff @(posedge Mclk) if (push && !flush) mem[wr_ptr] <= wr_data;
endmodule

// File: rtl/post_code_buffer.sv
// post_code_buffer: captures POST port writes and shows each code for a minimum hold time
module post_code_buffer
  import post_pkg::*;
#(
  parameter int          DEPTH   = 8,
  parameter int          HOLD_MS = HOLD_MS_DEFAULT,
  parameter logic [15:0] IO_ADDR = POST_IO_ADDR
) (
  input  logic                   Mclk,
  input  logic                   ResetN,
  post_code_buffer_if.slave      io,
  input  logic                   Strobe1ms,
  input  logic                   Clear,
  output logic [7:0]             BiosPostData,
  output logic                   PostValid,
  output logic [7:0]             LastCode,
  output logic [$clog2(DEPTH):0] Count,
  output logic                   Overflow
);
  localparam logic [9:0] HOLD_LAST = 10'(HOLD_MS - 1);
  post_state_t state, state_nxt;
  logic [9:0]  hold_cnt, hold_nxt;
  logic [7:0]  rd_data;
  logic        accept, pop, expire, empty, full;
  assign accept = io.IoWrStb && io.IoAddr == IO_ADDR && !Clear;
  post_code_fifo #(.DEPTH(DEPTH), .WIDTH(8)) u_fifo (
    .Mclk    (Mclk),
    .ResetN  (ResetN),
    .push    (accept),
    .pop     (pop),
    .flush   (Clear),
    .wr_data (io.IoData),
    .rd_data (rd_data),
    .count   (Count),
    .empty   (empty),
    .full    (full)
  );
  always_comb begin
    state_nxt = state;
    hold_nxt  = hold_cnt;
    pop       = 1'b0;
    expire    = state == ST_HOLD && Strobe1ms && hold_cnt == HOLD_LAST;
    if ((state == ST_IDLE || expire) && !empty) begin
      pop       = 1'b1;
      state_nxt = ST_HOLD;
      hold_nxt  = '0;
    end else if (expire) begin
      state_nxt = ST_IDLE;
      hold_nxt  = '0;
    end else if (state == ST_HOLD && Strobe1ms && hold_cnt != '1) begin
      hold_nxt  = hold_cnt + 1'b1;
    end
  end
  always_ff @(posedge Mclk or negedge ResetN) begin
    if (!ResetN) state <= ST_IDLE;
    else state <= Clear ? ST_IDLE : state_nxt;
  end
  always_ff @(posedge Mclk or negedge ResetN) begin
    if (!ResetN) begin
      hold_cnt     <= '0;
      BiosPostData <= 8'h00;
      PostValid    <= 1'b0;
      LastCode     <= 8'h00;
      Overflow     <= 1'b0;
    end else if (Clear) begin
      hold_cnt     <= '0;
      BiosPostData <= 8'h00;
      PostValid    <= 1'b0;
      LastCode     <= 8'h00;
      Overflow     <= 1'b0;
    end else begin
      hold_cnt <= hold_nxt;
      if (accept) LastCode <= io.IoData;
      // only flag a loss when the head is overwritten rather than displayed
      if (accept && full && !pop) Overflow <= 1'b1;
      if (pop) begin
        BiosPostData <= rd_data;
        PostValid    <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_post_code_buffer.sv
// tb_post_code_buffer: scoreboard bench for post_code_buffer with HOLD_MS=4, DEPTH=8
module tb_post_code_buffer;
  localparam int DEPTH = 8;
  logic       Mclk = 1'b0;
  logic       ResetN = 1'b0;
  logic       Strobe1ms = 1'b0;
  logic       Clear = 1'b0;
  logic [7:0] BiosPostData, LastCode;
  logic       PostValid, Overflow;
  logic [3:0] Count;
  logic [7:0] exp_q[$];
  logic [7:0] prev_disp = 8'h00;
  int         n_chk = 0;
  int         n_err = 0;
  post_code_buffer_if io();
  post_code_buffer #(.DEPTH(DEPTH), .HOLD_MS(4), .IO_ADDR(16'h0080)) dut (
    .Mclk         (Mclk),
    .ResetN       (ResetN),
    .io           (io.slave),
    .Strobe1ms    (Strobe1ms),
    .Clear        (Clear),
    .BiosPostData (BiosPostData),
    .PostValid    (PostValid),
    .LastCode     (LastCode),
    .Count        (Count),
    .Overflow     (Overflow)
  );
  always #5 Mclk = ~Mclk;
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  task automatic check(input string tag, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask
  // each newly displayed code must be the next one the model expects
  always @(posedge Mclk) begin
    #1;
    if (PostValid && BiosPostData != prev_disp) begin
      if (exp_q.size() == 0) check("disp_unexpected", 16'(exp_q.size()), 16'd1);
      else check("disp_order", {8'h00, BiosPostData}, {8'h00, exp_q.pop_front()});
    end
    prev_disp = BiosPostData;
  end
  task automatic wr(input logic [15:0] a, input logic [7:0] d);
    @(negedge Mclk);
    io.IoWrStb = 1'b1;
    io.IoAddr  = a;
    io.IoData  = d;
    if (a == 16'h0080) begin
      if (exp_q.size() == DEPTH) void'(exp_q.pop_front());
      exp_q.push_back(d);
    end
  endtask
  task automatic idle(input int n);
    repeat (n) begin
      @(negedge Mclk);
      io.IoWrStb = 1'b0;
      Strobe1ms  = 1'b0;
      Clear      = 1'b0;
    end
  endtask
  task automatic strobe(input int n);
    repeat (n) begin
      @(negedge Mclk);
      io.IoWrStb = 1'b0;
      Strobe1ms  = 1'b1;
      @(negedge Mclk);
      Strobe1ms  = 1'b0;
    end
  endtask
  task automatic check_reset_vals(input string tag);
    check({tag, "_disp"}, {8'h00, BiosPostData}, 16'h0000);
    check({tag, "_last"}, {8'h00, LastCode}, 16'h0000);
    check({tag, "_valid"}, {15'h0, PostValid}, 16'h0000);
    check({tag, "_count"}, {12'h0, Count}, 16'h0000);
    check({tag, "_ovf"}, {15'h0, Overflow}, 16'h0000);
  endtask
  initial begin
    io.IoWrStb = 1'b0;
    io.IoAddr  = 16'h0000;
    io.IoData  = 8'h00;
    repeat (2) @(negedge Mclk);
    check_reset_vals("reset");
    ResetN = 1'b1;
    wr(16'h0080, 8'h3A);
    idle(2);
    check("t1_disp", {8'h00, BiosPostData}, 16'h003A);
    check("t1_valid", {15'h0, PostValid}, 16'h0001);
    check("t1_last", {8'h00, LastCode}, 16'h003A);
    check("t1_count", {12'h0, Count}, 16'h0000);
    strobe(4);
    wr(16'h0081, 8'h11);
    wr(16'h0380, 8'h22);
    idle(2);
    check("t2_disp", {8'h00, BiosPostData}, 16'h003A);
    check("t2_last", {8'h00, LastCode}, 16'h003A);
    check("t2_count", {12'h0, Count}, 16'h0000);
    check("t2_ovf", {15'h0, Overflow}, 16'h0000);
    wr(16'h0080, 8'h01);
    wr(16'h0080, 8'h02);
    wr(16'h0080, 8'h03);
    idle(1);
    check("t3_last", {8'h00, LastCode}, 16'h0003);
    check("t3_disp01", {8'h00, BiosPostData}, 16'h0001);
    check("t3_count", {12'h0, Count}, 16'h0002);
    strobe(3);
    check("t3_hold01", {8'h00, BiosPostData}, 16'h0001);
    strobe(1);
    check("t3_disp02", {8'h00, BiosPostData}, 16'h0002);
    strobe(4);
    check("t3_disp03", {8'h00, BiosPostData}, 16'h0003);
    strobe(4);
    check("t3_idle_disp", {8'h00, BiosPostData}, 16'h0003);
    check("t3_idle_valid", {15'h0, PostValid}, 16'h0001);
    wr(16'h0080, 8'hAA);
    idle(1);
    for (int i = 1; i <= 8; i++) wr(16'h0080, 8'(i));
    wr(16'h0080, 8'h09);
    idle(1);
    check("t4_count", {12'h0, Count}, 16'h0008);
    check("t4_ovf", {15'h0, Overflow}, 16'h0001);
    check("t4_disp", {8'h00, BiosPostData}, 16'h00AA);
    strobe(4);
    check("t4_after_aa", {8'h00, BiosPostData}, 16'h0002);
    strobe(28);
    check("t4_disp09", {8'h00, BiosPostData}, 16'h0009);
    strobe(4);
    check("t4_drained", {12'h0, Count}, 16'h0000);
    wr(16'h0080, 8'h60);
    wr(16'h0080, 8'h61);
    idle(1);
    @(negedge Mclk);
    Clear      = 1'b1;
    io.IoWrStb = 1'b1;
    io.IoAddr  = 16'h0080;
    io.IoData  = 8'h55;
    exp_q.delete();
    idle(1);
    check_reset_vals("clear");
    idle(3);
    strobe(8);
    check("clear_no55_disp", {8'h00, BiosPostData}, 16'h0000);
    check("clear_no55_valid", {15'h0, PostValid}, 16'h0000);
    wr(16'h0080, 8'h71);
    wr(16'h0080, 8'h72);
    wr(16'h0080, 8'h73);
    wr(16'h0080, 8'h74);
    idle(1);
    check("t6_count", {12'h0, Count}, 16'h0003);
    check("t6_disp", {8'h00, BiosPostData}, 16'h0071);
    #2;
    ResetN = 1'b0;
    exp_q.delete();
    #1;
    check_reset_vals("async");
    @(negedge Mclk);
    ResetN = 1'b1;
    wr(16'h0080, 8'h7E);
    idle(2);
    check("t6_new_disp", {8'h00, BiosPostData}, 16'h007E);
    check("t6_new_last", {8'h00, LastCode}, 16'h007E);
    check("t6_new_valid", {15'h0, PostValid}, 16'h0001);
    check("sb_empty", 16'(exp_q.size()), 16'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
